pr_timer: RTL and testbench

PR_TIMER -- requirements
Module: pr_timer

---
 rtl/pr_timer.sv | 134 +++++++++++++
 tb/tb_pr_timer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_timer.sv
// pr_timer: memory-mapped down-counter with one-shot and auto-reload modes.
// Registers (word offsets): 0 CTRL {IM, Mode[1:0], Enable}, 1 PRESET,
// 2 COUNT (read-only), 3 reserved. Read data is registered (1-cycle latency).
module pr_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  PrBE,
  input  logic        IOWrite,
  output logic [31:0] PrRD,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [31:0] rd_q, rd_d;
  logic        irq_flag_q, irq_flag_d;

  logic        sel;
  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [31:0] be_mask;

  logic        enable;
  logic [1:0]  mode;
  logic        im;
  logic        auto_reload;

  assign enable      = ctrl_q[0];
  assign mode        = ctrl_q[2:1];
  assign im          = ctrl_q[3];
  assign auto_reload = (mode == 2'b01);

  // Address decode and write strobes for the 16-byte register window
  always_comb begin
    sel       = (PrAddr[31:4] == BASE_ADDR[31:4]);
    offset    = PrAddr[3:2];
    wr_ctrl   = IOWrite && sel && (offset == 2'd0);
    wr_preset = IOWrite && sel && (offset == 2'd1);
    be_mask   = {{8{PrBE[3]}}, {8{PrBE[2]}}, {8{PrBE[1]}}, {8{PrBE[0]}}};
  end

  // Timer FSM next state, then bus writes layered on top so they win
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          state_d = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          state_d = LOAD;
        end else begin
          ctrl_d[0]  = 1'b0;
          irq_flag_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl) begin
      if (PrBE[0]) ctrl_d = PrWD[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = (preset_q & ~be_mask) | (PrWD & be_mask);
      irq_flag_d = 1'b0;
    end
  end

  // Read mux: addressed register as it stands before the edge, 0 when unselected
  always_comb begin
    rd_d = '0;
    if (sel) begin
      case (offset)
        2'd0:    rd_d = {28'd0, ctrl_q};
        2'd1:    rd_d = preset_q;
        2'd2:    rd_d = count_q;
        default: rd_d = '0;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      rd_q       <= rd_d;
    end
  end

  assign PrRD = rd_q;
  assign IRQ  = (irq_flag_q & im) | ((state_q == INT) & auto_reload & im);

endmodule

// File: tb/tb_pr_timer.sv
// tb_pr_timer: randomized and directed bus traffic against a reference model
// that tracks the timer as a loaded value plus elapsed edges.
module tb_pr_timer;

  localparam logic [31:0] BASE      = 32'h0000_7F00;
  localparam logic [31:2] IDLE_ADDR = BASE[31:2] + 30'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        IOWrite;
  logic [31:0] PrRD;
  logic        IRQ;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  event chk_ev;

  // Reference model: phase 0 idle, 1 reload pending, 2 counting, 3 terminal
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_load, m_hold;
  longint      m_age;
  int          m_phase;

  pr_timer #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .PrAddr (PrAddr),
    .PrWD   (PrWD),
    .PrBE   (PrBE),
    .IOWrite(IOWrite),
    .PrRD   (PrRD),
    .IRQ    (IRQ)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to time-stamp expected responses
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:2] wa(input int off);
    return BASE[31:2] + 30'(off);
  endfunction

  function automatic logic [31:0] count_now();
    if (m_phase == 3) return 32'd0;
    if (m_phase == 2) return (longint'(m_load) > m_age) ? m_load - 32'(m_age) : 32'd0;
    return m_hold;
  endfunction

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_load = 0; m_hold = 0; m_age = 0; m_phase = 0;
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic irq, input int due);
    exp_t e;
    e.rd = rd; e.irq = irq; e.due = due;
    exp_q.push_back(e);
  endtask

  // Advance the model by one edge with the given bus inputs and queue the result
  task automatic model_step(input logic [31:2] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic wr);
    logic        sel;
    logic [1:0]  off;
    logic [31:0] rd;
    logic        irq;
    longint      lim;
    sel = (addr[31:4] == BASE[31:4]);
    off = addr[3:2];
    rd  = 32'd0;
    if (sel) begin
      if (off == 2'd0) rd = {28'd0, m_im, m_mode, m_en};
      else if (off == 2'd1) rd = m_preset;
      else if (off == 2'd2) rd = count_now();
    end
    case (m_phase)
      0: if (m_en) m_phase = 1;
      1: begin m_load = m_preset; m_age = 0; m_phase = 2; end
      2: begin
        if (!m_en) begin
          m_hold  = count_now();
          m_phase = 0;
        end else begin
          m_age = m_age + 1;
          lim   = (m_load == 0) ? 1 : longint'(m_load);
          if (m_age >= lim) m_phase = 3;
        end
      end
      default: begin
        m_hold = 0;
        if (m_mode == 2'b01) m_phase = 1;
        else begin m_en = 0; m_flag = 1; m_phase = 0; end
      end
    endcase
    if (wr && sel && off == 2'd0) begin
      if (be[0]) {m_im, m_mode, m_en} = wd[3:0];
      m_flag = 0;
    end
    if (wr && sel && off == 2'd1) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_preset[8*i +: 8] = wd[8*i +: 8];
      m_flag = 0;
    end
    irq = (m_flag & m_im) | ((m_phase == 3) & (m_mode == 2'b01) & m_im);
    push_exp(rd, irq, cyc + 1);
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (PrRD !== e.rd) begin
      errors++;
      $display("[TB] FAIL prrd cyc=%0d got=%h exp=%h", cyc, PrRD, e.rd);
    end
    checks++;
    if (IRQ !== e.irq) begin
      errors++;
      $display("[TB] FAIL irq cyc=%0d got=%b exp=%b", cyc, IRQ, e.irq);
    end
  endtask

  // Monitor: compare every response that has come due
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check_output(exp_q.pop_front());
      end
    end
  end

  // One bus cycle: drive just after the edge, model the following edge
  task automatic apply_stimulus(input logic [31:2] addr, input logic [31:0] wd,
                                input logic [3:0] be, input logic wr);
    @(posedge clk);
    #1;
    PrAddr = addr; PrWD = wd; PrBE = be; IOWrite = wr;
    model_step(addr, wd, be, wr);
  endtask

  task automatic wr_reg(input int off, input logic [31:0] data, input logic [3:0] be);
    apply_stimulus(wa(off), data, be, 1'b1);
  endtask

  task automatic rd_reg(input int off, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(wa(off), 32'd0, 4'hF, 1'b0);
  endtask

  // Asynchronous reset pulse between edges, outputs checked immediately
  task automatic pulse_reset(input int hold);
    @(posedge clk);
    #1;
    PrAddr = IDLE_ADDR; IOWrite = 1'b0; PrBE = 4'h0; PrWD = 32'd0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    push_exp(32'd0, 1'b0, cyc);
    #1;
    -> chk_ev;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      push_exp(32'd0, 1'b0, cyc);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_step(PrAddr, PrWD, PrBE, IOWrite);
  endtask

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    logic [31:2] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    rst = 1'b0; PrAddr = IDLE_ADDR; PrWD = 32'd0; PrBE = 4'h0; IOWrite = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      push_exp(32'd0, 1'b0, cyc);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_step(PrAddr, PrWD, PrBE, IOWrite);

    rd_reg(0, 1); rd_reg(1, 1); rd_reg(2, 1);

    wr_reg(1, 32'd5, 4'hF);
    wr_reg(0, 32'h9, 4'hF);
    rd_reg(2, 10);
    rd_reg(0, 2);
    wr_reg(0, 32'h8, 4'hF);
    rd_reg(0, 2);

    wr_reg(1, 32'd3, 4'hF);
    wr_reg(0, 32'hB, 4'hF);
    rd_reg(2, 22);
    rd_reg(0, 1);
    wr_reg(0, 32'h0, 4'hF);
    rd_reg(2, 4);

    wr_reg(1, 32'd0, 4'hF);
    wr_reg(1, 32'h1234_5678, 4'b0100);
    wr_reg(1, 32'h1234_5678, 4'b0001);
    rd_reg(1, 1);
    wr_reg(2, 32'hDEAD_BEEF, 4'hF);
    rd_reg(2, 1);
    apply_stimulus(IDLE_ADDR, 32'hFFFF_FFFF, 4'hF, 1'b1);
    apply_stimulus(IDLE_ADDR + 30'd1, 32'd0, 4'hF, 1'b0);
    rd_reg(1, 1); rd_reg(0, 1);

    wr_reg(1, 32'd0, 4'hF);
    wr_reg(0, 32'h9, 4'hF);
    rd_reg(2, 6);
    rd_reg(0, 1);

    wr_reg(1, 32'd1, 4'hF);
    wr_reg(0, 32'h9, 4'hF);
    rd_reg(2, 3);
    wr_reg(0, 32'h9, 4'hF);
    rd_reg(0, 6);
    wr_reg(0, 32'h0, 4'hF);

    wr_reg(1, 32'd100, 4'hF);
    wr_reg(0, 32'h9, 4'hF);
    rd_reg(2, 20);
    wr_reg(0, 32'h0, 4'hF);
    rd_reg(2, 5);
    wr_reg(0, 32'h9, 4'hF);
    rd_reg(2, 10);
    pulse_reset(2);
    rd_reg(0, 1); rd_reg(1, 1); rd_reg(2, 1);

    wr_reg(1, 32'd2, 4'hF);
    wr_reg(0, 32'h1, 4'hF);
    rd_reg(2, 8);
    wr_reg(0, 32'h8, 4'hF);
    rd_reg(0, 3);

    for (int n = 0; n < 400; n++) begin
      int off;
      logic wr;
      off  = $urandom_range(0, 3);
      addr = wa(off);
      if ($urandom_range(0, 99) < 12) addr = addr ^ (30'd1 << $urandom_range(2, 29));
      wr = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (off == 1 && $urandom_range(0, 7) != 0) wd = 32'($urandom_range(0, 6));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      apply_stimulus(addr, wd, be, wr);
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
